// File: rtl/soma_scan_ctrl.sv
// Per-timestep soma sweep controller: issues one update/clear beat per neuron,
// captures fire results one cycle later and queues fired addresses for a valid/ready consumer.
module soma_scan_ctrl #(
  parameter int NNW        = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic           clk_soma,
  input  logic           rst,
  input  logic           tick_start,
  input  logic           clear_start,
  input  logic [NNW-1:0] neuron_num,
  output logic           config_soma_vld,
  output logic [NNW-1:0] config_soma_vm_addr,
  output logic           config_soma_clear,
  input  logic           soma_spk_out_fire,
  output logic           spk_vld,
  output logic [NNW-1:0] spk_addr,
  input  logic           spk_rdy,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] ROOM_MAX = (FIFO_AW+1)'(FIFO_DEPTH - 2);

  state_t           r_state, w_state_n;
  logic             r_mode, w_mode_n;
  logic [NNW-1:0]   r_num, w_num_n;
  logic [NNW-1:0]   r_cnt, w_cnt_n;
  logic             r_vld_d1, r_clr_d1;
  logic [NNW-1:0]   r_addr_d1;
  logic [NNW-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0] r_count, w_count_n;
  logic             w_push, w_pop, w_room, w_issue, w_cur_mode;
  logic [NNW-1:0]   w_cur_cnt, w_cur_num;

  assign w_push    = r_vld_d1 & ~r_clr_d1 & soma_spk_out_fire;
  assign w_pop     = spk_vld & spk_rdy;
  assign w_count_n = r_count + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};
  // Beats are registered, so room is judged on the occupancy of the cycle the beat appears in.
  assign w_room    = (w_count_n <= ROOM_MAX);
  assign spk_vld   = (r_count != '0);
  assign spk_addr  = spk_vld ? r_mem[r_rp] : '0;

  always_comb begin
    w_state_n  = r_state;
    w_mode_n   = r_mode;
    w_num_n    = r_num;
    w_cnt_n    = r_cnt;
    w_issue    = 1'b0;
    w_cur_cnt  = r_cnt;
    w_cur_num  = r_num;
    w_cur_mode = r_mode;
    unique case (r_state)
      IDLE: if (clear_start || tick_start) begin
        w_mode_n   = clear_start;
        w_num_n    = neuron_num;
        w_cnt_n    = '0;
        w_cur_mode = clear_start;
        w_cur_num  = neuron_num;
        w_cur_cnt  = '0;
        w_state_n  = (neuron_num == '0) ? DONE : SCAN;
      end
      DRAIN: if (!config_soma_vld && !r_vld_d1 && !spk_vld) w_state_n = DONE;
      DONE:  w_state_n = IDLE;
      default: ;
    endcase
    if (w_state_n == SCAN && w_room) begin
      w_issue = 1'b1;
      w_cnt_n = w_cur_cnt + NNW'(1);
      if (w_cur_cnt == w_cur_num - NNW'(1)) w_state_n = DRAIN;
    end
  end

  always_ff @(posedge clk_soma or posedge rst) begin
    if (rst) begin
      r_state             <= IDLE;
      r_mode              <= 1'b0;
      r_num               <= '0;
      r_cnt               <= '0;
      config_soma_vld     <= 1'b0;
      config_soma_vm_addr <= '0;
      config_soma_clear   <= 1'b0;
      r_vld_d1            <= 1'b0;
      r_addr_d1           <= '0;
      r_clr_d1            <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
    end else begin
      r_state             <= w_state_n;
      r_mode              <= w_mode_n;
      r_num               <= w_num_n;
      r_cnt               <= w_cnt_n;
      config_soma_vld     <= w_issue;
      config_soma_vm_addr <= w_issue ? w_cur_cnt : '0;
      config_soma_clear   <= w_issue & w_cur_mode;
      r_vld_d1            <= config_soma_vld;
      r_addr_d1           <= config_soma_vm_addr;
      r_clr_d1            <= config_soma_clear;
      busy                <= (w_state_n != IDLE);
      done                <= (w_state_n == DONE);
    end
  end

  always_ff @(posedge clk_soma or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + FIFO_AW'(1);
      if (w_pop)  r_rp <= r_rp + FIFO_AW'(1);
      r_count <= w_count_n;
    end
  end

  always_ff @(posedge clk_soma) begin
    if (w_push) r_mem[r_wp] <= r_addr_d1;
  end

  // The issue throttle guarantees a free slot for every capture.
  always @(posedge clk_soma) begin
    if (!rst && w_push) assert (r_count != CNT_FULL) else $error("fired-address FIFO push while full");
  end

endmodule

// File: tb/tb_soma_scan_ctrl.sv
// Randomized bench for soma_scan_ctrl: a queue-based model of the fired-address
// stream and beat ordering is compared cycle by cycle against the DUT.
module tb_soma_scan_ctrl;
  localparam int NNW = 12;
  localparam int D   = 8;

  logic           clk_soma = 1'b0;
  logic           rst = 1'b1;
  logic           tick_start = 1'b0, clear_start = 1'b0;
  logic [NNW-1:0] neuron_num = '0;
  logic           config_soma_vld, config_soma_clear;
  logic [NNW-1:0] config_soma_vm_addr;
  logic           soma_spk_out_fire = 1'b0;
  logic           spk_vld;
  logic [NNW-1:0] spk_addr;
  logic           spk_rdy = 1'b0;
  logic           busy, done;

  int vectors = 0, miscompares = 0;
  bit fire_tbl [0:4095];
  int m_q [$];

  soma_scan_ctrl #(.NNW(NNW), .FIFO_DEPTH(D), .FIFO_AW(3)) dut (
    .clk_soma(clk_soma), .rst(rst), .tick_start(tick_start), .clear_start(clear_start),
    .neuron_num(neuron_num), .config_soma_vld(config_soma_vld),
    .config_soma_vm_addr(config_soma_vm_addr), .config_soma_clear(config_soma_clear),
    .soma_spk_out_fire(soma_spk_out_fire), .spk_vld(spk_vld), .spk_addr(spk_addr),
    .spk_rdy(spk_rdy), .busy(busy), .done(done)
  );

  always #5 clk_soma = ~clk_soma;

  // One sweep: start pulse in cycle 0, then check every cycle until done.
  task automatic run_sweep(input string tag, input int n, input bit clr, input bit both,
                           input int fire_pct, input int rdy_hold, input int rdy_pct);
    int  exp_spk [$];
    int  beats = 0, pops = 0, pa = 0, budget;
    bit  pv = 0, pclr = 0, done_seen = 0, push, pop;
    bit  eclr;
    eclr   = clr | both;
    budget = n * 30 + 200;
    if (fire_pct >= 0) for (int a = 0; a < n; a++) fire_tbl[a] = ($urandom_range(99) < fire_pct);
    for (int a = 0; a < n; a++) if (!eclr && fire_tbl[a]) exp_spk.push_back(a);
    m_q.delete();
    @(posedge clk_soma); #1;
    neuron_num = NNW'(n);
    tick_start = both | ~clr;
    clear_start = eclr;
    soma_spk_out_fire = 1'b0;
    spk_rdy = 1'b0;
    for (int cyc = 1; cyc <= budget && !done_seen; cyc++) begin
      @(posedge clk_soma); #1;
      if (cyc == 1 || cyc == 4) begin tick_start = 0; clear_start = 0; end
      if (cyc == 3 && n >= 4) begin
        tick_start = 1; clear_start = 1'($urandom_range(1)); neuron_num = NNW'($urandom);
      end
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL %s busy cyc=%0d got=%b exp=1", tag, cyc, busy); end
      vectors++;
      if (spk_vld !== (m_q.size() != 0) || (m_q.size() != 0 && spk_addr !== NNW'(m_q[0]))) begin
        miscompares++;
        $display("FAIL %s spk_port cyc=%0d got vld=%b addr=%0d exp vld=%0d addr=%0d", tag, cyc,
                 spk_vld, spk_addr, m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 0);
      end
      if (beats < n && m_q.size() <= D - 2) begin
        vectors++;
        if (config_soma_vld !== 1'b1) begin miscompares++; $display("FAIL %s stall cyc=%0d got vld=%b exp=1 occ=%0d", tag, cyc, config_soma_vld, m_q.size()); end
      end
      vectors++;
      if (config_soma_vld === 1'b1 && (beats >= n || m_q.size() > D - 2)) begin
        miscompares++; $display("FAIL %s extra_beat cyc=%0d beats=%0d n=%0d occ=%0d", tag, cyc, beats, n, m_q.size());
      end
      if (config_soma_vld === 1'b1) begin
        vectors++;
        if (config_soma_vm_addr !== NNW'(beats) || config_soma_clear !== eclr) begin
          miscompares++;
          $display("FAIL %s beat got addr=%0d clr=%b exp addr=%0d clr=%b", tag, config_soma_vm_addr, config_soma_clear, beats, eclr);
        end
        beats++;
      end
      if (done === 1'b1) begin
        vectors++;
        if (beats != n || m_q.size() != 0 || pops != exp_spk.size() || pv) begin
          miscompares++;
          $display("FAIL %s done_early got beats=%0d pops=%0d occ=%0d exp beats=%0d pops=%0d", tag, beats, pops, m_q.size(), n, exp_spk.size());
        end
        done_seen = 1;
      end
      soma_spk_out_fire = pv && fire_tbl[pa];
      spk_rdy = (cyc >= rdy_hold) && ($urandom_range(99) < rdy_pct);
      push = pv && !pclr && fire_tbl[pa];
      pop  = (m_q.size() != 0) && spk_rdy;
      if (pop) begin
        vectors++;
        if (pops >= exp_spk.size() || spk_addr !== NNW'(exp_spk[pops])) begin
          miscompares++;
          $display("FAIL %s pop_order got=%0d exp=%0d", tag, spk_addr, (pops < exp_spk.size()) ? exp_spk[pops] : -1);
        end
        pops++;
        void'(m_q.pop_front());
      end
      if (push) m_q.push_back(pa);
      pv = config_soma_vld; pa = int'(config_soma_vm_addr); pclr = config_soma_clear;
    end
    vectors++;
    if (!done_seen) begin miscompares++; $display("FAIL %s timeout got done=0 exp=1 beats=%0d", tag, beats); end
    soma_spk_out_fire = 0; spk_rdy = 0;
    @(posedge clk_soma); #1;
    vectors++;
    if (busy !== 0 || done !== 0 || config_soma_vld !== 0) begin
      miscompares++; $display("FAIL %s post_done got busy=%b done=%b vld=%b exp 0", tag, busy, done, config_soma_vld);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if ({config_soma_vld, config_soma_vm_addr, config_soma_clear, spk_vld, spk_addr, busy, done} !== '0) begin
      miscompares++; $display("FAIL reset_state got vld=%b addr=%0d spk_vld=%b busy=%b done=%b exp 0", config_soma_vld, config_soma_vm_addr, spk_vld, busy, done);
    end
    repeat (2) @(posedge clk_soma);
    #1 rst = 0;
  endtask

  task automatic test_basic;
    for (int a = 0; a < 4; a++) fire_tbl[a] = (a == 1 || a == 3);
    run_sweep("basic", 4, 0, 0, -1, 0, 100);
  endtask

  task automatic test_backpressure;
    run_sweep("backpressure", 16, 0, 0, 100, 30, 100);
  endtask

  task automatic test_clear;
    run_sweep("clear", 5, 1, 0, 100, 0, 100);
  endtask

  task automatic test_both_starts;
    run_sweep("both_starts", 9, 1, 1, 100, 0, 100);
  endtask

  task automatic test_zero;
    run_sweep("zero", 0, 0, 0, 100, 0, 100);
  endtask

  task automatic test_reset_mid;
    bit pv = 0;
    for (int a = 0; a < 16; a++) fire_tbl[a] = 1;
    @(posedge clk_soma); #1;
    neuron_num = 16; tick_start = 1; spk_rdy = 0; soma_spk_out_fire = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk_soma); #1;
      tick_start = 0;
      soma_spk_out_fire = pv;
      pv = config_soma_vld;
    end
    vectors++;
    if (spk_vld !== 1'b1) begin miscompares++; $display("FAIL rst_mid_queued got spk_vld=%b exp=1", spk_vld); end
    #3 rst = 1;
    #1;
    vectors++;
    if ({config_soma_vld, config_soma_vm_addr, config_soma_clear, spk_vld, spk_addr, busy, done} !== '0) begin
      miscompares++; $display("FAIL rst_mid_async got vld=%b spk_vld=%b busy=%b done=%b exp 0", config_soma_vld, spk_vld, busy, done);
    end
    soma_spk_out_fire = 0;
    repeat (2) begin
      @(posedge clk_soma); #1;
      vectors++;
      if (done !== 0 || spk_vld !== 0) begin miscompares++; $display("FAIL rst_mid_hold got done=%b spk_vld=%b exp 0", done, spk_vld); end
    end
    rst = 0;
    run_sweep("after_rst", 6, 0, 0, 50, 0, 100);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_sweep("random", int'($urandom_range(40, 1)), 1'($urandom_range(3) == 0), 1'b0,
                int'($urandom_range(100)), int'($urandom_range(10)), int'($urandom_range(100, 20)));
  endtask

  task automatic test_max_num;
    run_sweep("max_num", 4095, 0, 0, 5, 0, 100);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_clear;
    test_both_starts;
    test_zero;
    test_reset_mid;
    test_random;
    test_max_num;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/soma_scan_ctrl.md
Name: soma_scan_ctrl

Overview:
- Drives the soma update interface for each timestep: sweeps neuron addresses, issuing a one-cycle valid/address/clear beat per neuron.
- Samples the soma fire output one cycle later and queues the addresses of fired neurons in a small FIFO.
- Presents queued addresses on a valid/ready spike port toward spike-out / axon routing.
- Also runs a clear sweep that zeroes every Vm entry.

Parameters:
- NNW, 12, neuron number / address width
- FIFO_DEPTH, 8, fired-address FIFO entries (power of two, >= 4)
- FIFO_AW, 3, log2(FIFO_DEPTH)

Ports:
- clk_soma  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- tick_start  in  1  one-cycle pulse: start update sweep
- clear_start  in  1  one-cycle pulse: start clear sweep
- neuron_num  in  NNW  neurons to sweep (addresses 0..neuron_num-1); sampled at start
- config_soma_vld  out  1  per-neuron update beat
- config_soma_vm_addr  out  NNW  neuron address of current beat
- config_soma_clear  out  1  beat is a clear (Vm := 0)
- soma_spk_out_fire  in  1  soma fire result, valid the cycle after a beat
- spk_vld  out  1  fired address available
- spk_addr  out  NNW  fired neuron address
- spk_rdy  in  1  consumer accepts when spk_vld && spk_rdy
- busy  out  1  sweep in progress (state != IDLE)
- done  out  1  one-cycle pulse at sweep completion

Behaviour:
- Reset (async, active-high): state IDLE; FIFO emptied; config_soma_vld=0, config_soma_vm_addr=0, config_soma_clear=0, spk_vld=0, spk_addr=0, busy=0, done=0.
- All outputs are registered, except spk_vld/spk_addr, which come straight from FIFO state (spk_vld = !empty, spk_addr = head entry).
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - clear_start -> SCAN with mode=clear.
  - else tick_start -> SCAN with mode=update.
  - Both high: clear wins; tick is dropped.
  - Latch neuron_num and reset address counter to 0.
  - neuron_num==0: go straight to DONE; no beats issued.
- SCAN: issue a beat (vld=1, addr=counter, clear=mode) in a cycle only if FIFO free slots >= 2 (one reserved for the in-flight capture). Otherwise vld=0 and the counter holds (stall).
- Issue after start: a start pulse in cycle 0 gives the first beat in cycle 1 (if the FIFO has room).
- Counter increments per issued beat. After issuing address neuron_num-1, go to DRAIN.
- Capture: beat registered as (vld_d1, addr_d1, clear_d1). In the cycle vld_d1=1 && clear_d1=0 && soma_spk_out_fire=1, push addr_d1. fire is ignored when vld_d1=0 or clear_d1=1.
- Spike latency: beat in cycle N -> push in cycle N+1 -> spk_vld high in cycle N+2 (if FIFO was empty).
- FIFO:
  - Pop on spk_vld && spk_rdy.
  - Simultaneous push and pop keeps the count unchanged.
  - Order is preserved (ascending address within a sweep).
  - Overflow cannot occur by construction. A push when full is a design error: flag it with an assertion in simulation.
- DRAIN: wait for the final capture (vld_d1 low) and an empty FIFO, then go to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, return to IDLE.
- tick_start/clear_start while busy: ignored, with no effect on the current sweep.
- neuron_num changes mid-sweep: no effect (latched copy used).
- Counter width is NNW. neuron_num = 2^NNW-1 sweeps 0..2^NNW-2; the counter never wraps.
- Reset mid-sweep: immediate abort, FIFO contents discarded, no done pulse.

Test Plan:
- neuron_num=4, tick_start, spk_rdy=1, fire high in the cycles after beats for addr 1 and 3 -> vld beats addr 0,1,2,3 in consecutive cycles from cycle 1; spk_addr 1 then 3; done one pulse; config_soma_clear=0 throughout.
- neuron_num=16, all fire, spk_rdy=0 for 30 cycles then 1 -> beats stall once FIFO holds 7; no push while full; after release all 16 addresses 0..15 are delivered in order; done only after the last pop.
- clear_start, neuron_num=5, fire forced 1 -> 5 beats with config_soma_clear=1; spk_vld never asserts; done pulses.
- tick_start and clear_start in the same cycle -> clear sweep runs; a second tick_start mid-sweep is ignored (exactly neuron_num beats).
- neuron_num=0, tick_start -> no vld beat; done pulses within 2 cycles.
- rst asserted mid-sweep with 3 entries queued -> all outputs 0 asynchronously; FIFO empty; no done; a fresh tick_start afterward starts from addr 0.
